mdio_receiver: RTL

- MDIO management-device (PHY-side) receiver. It sits directly downstream of the MDIO generator and consumes its MDC, MDIO_OUT and MDIO_OE outputs.
- Decodes 32-bit Clause-22 frames: ST(2) OP(2) PHYAD(5) REGAD(5) TA(2) DATA(16), MSB first.
- Write frames: presents the address and data to a local register file with a write strobe.
- Read frames: requests register data and serialises it back to the generator on MDIO_IN.

---
 rtl/mdio_receiver_if.sv | 26 ++
 rtl/mdio_receiver.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_receiver_if.sv
// Bundle for the mdio_receiver: serial MDIO lines plus the local register-file port.
// master = generator / register-file side, slave = mdio_receiver.
interface mdio_receiver_if;
    logic        MDC;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic [15:0] RD_DATA;
    logic        MDIO_IN;
    logic        MDIO_IN_OE;
    logic [4:0]  ADDR;
    logic [15:0] WR_DATA;
    logic        WR_STB;
    logic        RD_REQ;
    logic        FRAME_DONE;
    logic        FRAME_ERR;

    modport master (
        output MDC, MDIO_OUT, MDIO_OE, RD_DATA,
        input  MDIO_IN, MDIO_IN_OE, ADDR, WR_DATA, WR_STB, RD_REQ, FRAME_DONE, FRAME_ERR
    );

    modport slave (
        input  MDC, MDIO_OUT, MDIO_OE, RD_DATA,
        output MDIO_IN, MDIO_IN_OE, ADDR, WR_DATA, WR_STB, RD_REQ, FRAME_DONE, FRAME_ERR
    );
endinterface

// File: rtl/mdio_receiver.sv
// Clause-22 MDIO PHY-side receiver: decodes write/read frames, serialises read data back.
// Optional PHYAD filtering is enabled by defining MDIO_ADDR_CHECK_EN.
module mdio_receiver #(
    parameter logic [4:0] PHY_ADDR = 5'd1,
    parameter logic [1:0] ST_CODE  = 2'b01
) (
    input  logic           clk,
    input  logic           rst,
    mdio_receiver_if.slave bus
);

    typedef enum logic [2:0] {IDLE, HDR, WTA, WDAT, RTA, RDAT, SKIP} state_t;

`ifdef MDIO_ADDR_CHECK_EN
    localparam logic ADDR_CHECK = 1'b1;
`else
    localparam logic ADDR_CHECK = 1'b0;
`endif

    state_t      state_q, state_d;
    logic        mdc_q;
    logic [4:0]  cnt_q, cnt_d;
    logic [13:0] hdr_q, hdr_d;
    logic [15:0] wsh_q, wsh_d;
    logic [15:0] tx_q, tx_d;
    logic [4:0]  addr_q, addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        wr_stb_q, wr_stb_d;
    logic        rd_req_q, rd_req_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        mdio_in_q, mdio_in_d;
    logic        mdio_in_oe_q, mdio_in_oe_d;

    logic        rise_s;
    logic [13:0] hdr_shift_s;
    logic [15:0] wsh_shift_s;
    logic [4:0]  cnt_inc_s;
    logic        op_ok_s;
    logic        phy_ok_s;

    assign rise_s      = bus.MDC & ~mdc_q;
    assign hdr_shift_s = {hdr_q[12:0], bus.MDIO_OUT};
    assign wsh_shift_s = {wsh_q[14:0], bus.MDIO_OUT};
    assign cnt_inc_s   = cnt_q + 5'd1;
    assign op_ok_s     = (hdr_shift_s[11:10] == 2'b01) || (hdr_shift_s[11:10] == 2'b10);
    assign phy_ok_s    = !ADDR_CHECK || (hdr_shift_s[9:5] == PHY_ADDR);

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mdc_q        <= 1'b0;
            cnt_q        <= 5'd0;
            hdr_q        <= 14'd0;
            wsh_q        <= 16'd0;
            tx_q         <= 16'd0;
            addr_q       <= 5'd0;
            wr_data_q    <= 16'd0;
            wr_stb_q     <= 1'b0;
            rd_req_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            mdio_in_q    <= 1'b0;
            mdio_in_oe_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mdc_q        <= bus.MDC;
            cnt_q        <= cnt_d;
            hdr_q        <= hdr_d;
            wsh_q        <= wsh_d;
            tx_q         <= tx_d;
            addr_q       <= addr_d;
            wr_data_q    <= wr_data_d;
            wr_stb_q     <= wr_stb_d;
            rd_req_q     <= rd_req_d;
            done_q       <= done_d;
            err_q        <= err_d;
            mdio_in_q    <= mdio_in_d;
            mdio_in_oe_q <= mdio_in_oe_d;
        end
    end

    // Frame decode: next state, counters, shift registers and strobes
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hdr_d        = hdr_q;
        wsh_d        = wsh_q;
        tx_d         = tx_q;
        addr_d       = addr_q;
        wr_data_d    = wr_data_q;
        wr_stb_d     = 1'b0;
        rd_req_d     = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        mdio_in_d    = mdio_in_q;
        mdio_in_oe_d = mdio_in_oe_q;

        case (state_q)
            IDLE: begin
                cnt_d = 5'd0;
                if (rise_s && bus.MDIO_OE && (bus.MDIO_OUT == ST_CODE[1])) begin
                    state_d = HDR;
                    cnt_d   = 5'd1;
                    hdr_d   = {13'd0, bus.MDIO_OUT};
                end else begin
                    state_d = IDLE;
                end
            end
            HDR: begin
                if (!bus.MDIO_OE) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 5'd0;
                end else if (rise_s) begin
                    hdr_d = hdr_shift_s;
                    cnt_d = cnt_inc_s;
                    if (cnt_q == 5'd13) begin
                        if ((hdr_shift_s[13:12] != ST_CODE) || !op_ok_s) begin
                            err_d   = 1'b1;
                            state_d = SKIP;
                        end else if (!phy_ok_s) begin
                            state_d = SKIP;
                        end else begin
                            addr_d = hdr_shift_s[4:0];
                            if (hdr_shift_s[11:10] == 2'b01) begin
                                state_d = WTA;
                            end else begin
                                state_d  = RTA;
                                rd_req_d = 1'b1;
                            end
                        end
                    end else begin
                        state_d = HDR;
                    end
                end else begin
                    state_d = HDR;
                end
            end
            WTA: begin
                if (!bus.MDIO_OE) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 5'd0;
                end else if (rise_s) begin
                    cnt_d = cnt_inc_s;
                    if ((cnt_q == 5'd14) && !bus.MDIO_OUT) begin
                        err_d   = 1'b1;
                        state_d = SKIP;
                    end else if (cnt_q == 5'd15) begin
                        err_d   = bus.MDIO_OUT;
                        state_d = bus.MDIO_OUT ? SKIP : WDAT;
                    end else begin
                        state_d = WTA;
                    end
                end else begin
                    state_d = WTA;
                end
            end
            WDAT: begin
                if (!bus.MDIO_OE) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 5'd0;
                end else if (rise_s) begin
                    wsh_d = wsh_shift_s;
                    cnt_d = cnt_inc_s;
                    if (cnt_q == 5'd31) begin
                        wr_data_d = wsh_shift_s;
                        wr_stb_d  = 1'b1;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                        cnt_d     = 5'd0;
                    end else begin
                        state_d = WDAT;
                    end
                end else begin
                    state_d = WDAT;
                end
            end
            RTA: begin
                if (rise_s) begin
                    cnt_d = cnt_inc_s;
                    if (cnt_q == 5'd14) begin
                        mdio_in_oe_d = 1'b1;
                        mdio_in_d    = 1'b0;
                    end else if (cnt_q == 5'd15) begin
                        tx_d      = bus.RD_DATA;
                        mdio_in_d = bus.RD_DATA[15];
                        state_d   = RDAT;
                    end else begin
                        state_d = RTA;
                    end
                end else begin
                    state_d = RTA;
                end
            end
            RDAT: begin
                if (rise_s) begin
                    cnt_d = cnt_inc_s;
                    // The count-31 rise is where the generator samples bit0, so release only then.
                    if (cnt_q == 5'd31) begin
                        mdio_in_oe_d = 1'b0;
                        mdio_in_d    = 1'b0;
                        done_d       = 1'b1;
                        state_d      = IDLE;
                        cnt_d        = 5'd0;
                    end else begin
                        tx_d      = {tx_q[14:0], 1'b0};
                        mdio_in_d = tx_q[14];
                    end
                end else begin
                    state_d = RDAT;
                end
            end
            SKIP: begin
                if (rise_s) begin
                    cnt_d = cnt_inc_s;
                    if (cnt_q == 5'd31) begin
                        state_d = IDLE;
                        cnt_d   = 5'd0;
                    end else begin
                        state_d = SKIP;
                    end
                end else begin
                    state_d = SKIP;
                end
            end
            default: begin
                state_d      = IDLE;
                cnt_d        = 5'd0;
                mdio_in_oe_d = 1'b0;
                mdio_in_d    = 1'b0;
            end
        endcase
    end

    assign bus.MDIO_IN    = mdio_in_q;
    assign bus.MDIO_IN_OE = mdio_in_oe_q;
    assign bus.ADDR       = addr_q;
    assign bus.WR_DATA    = wr_data_q;
    assign bus.WR_STB     = wr_stb_q;
    assign bus.RD_REQ     = rd_req_q;
    assign bus.FRAME_DONE = done_q;
    assign bus.FRAME_ERR  = err_q;

endmodule
